// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer constants, entry/CDB types and tag/index helpers.
// Tags are 1-based (tag 0 = "no tag"); entry index = tag - 1.
package reorder_buffer_pkg;

    localparam int unsigned ROB_SIZE   = 16;
    localparam int unsigned TAG_WIDTH  = 5;
    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned REG_WIDTH  = 5;
    localparam int unsigned PC_WIDTH   = 64;
    localparam int unsigned IDX_WIDTH  = $clog2(ROB_SIZE);

    typedef logic [TAG_WIDTH-1:0]  tag_t;
    typedef logic [IDX_WIDTH-1:0]  idx_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [REG_WIDTH-1:0]  reg_t;
    typedef logic [PC_WIDTH-1:0]   pc_t;

    typedef struct packed {
        logic  valid;
        logic  ready;
        logic  regwr;
        reg_t  rd;
        data_t value;
        pc_t   pc;
    } rob_entry_t;

    typedef struct packed {
        tag_t  tag;
        data_t value;
    } cdb_t;

    function automatic logic tag_in_range(input tag_t tag);
        return (tag != '0) && (32'(tag) <= ROB_SIZE);
    endfunction

    function automatic idx_t tag_to_idx(input tag_t tag);
        tag_t t;
        t = tag - tag_t'(1);
        return t[IDX_WIDTH-1:0];
    endfunction

    function automatic tag_t idx_to_tag(input idx_t idx);
        return tag_t'(idx) + tag_t'(1);
    endfunction

    function automatic idx_t next_idx(input idx_t idx);
        if (32'(idx) == ROB_SIZE - 1) begin
            return '0;
        end
        return idx + idx_t'(1);
    endfunction

endpackage

// File: rtl/rob_query_port.sv
// Combinational operand lookup: stored value if ready, else same-cycle CDB bypass
// (cdb1 has priority over cdb2).
module rob_query_port
    import reorder_buffer_pkg::*;
(
    input  logic [TAG_WIDTH-1:0]  query_tag,
    input  logic [ROB_SIZE-1:0]   entry_valid,
    input  logic [ROB_SIZE-1:0]   entry_ready,
    input  data_t                 entry_value [ROB_SIZE],
    input  cdb_t                  cdb1,
    input  cdb_t                  cdb2,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] value
);

    idx_t idx;
    logic hit;

    assign idx = tag_to_idx(query_tag);
    assign hit = tag_in_range(query_tag) && entry_valid[idx];

    always_comb begin
        ready = 1'b0;
        value = '0;
        if (hit) begin
            if (entry_ready[idx]) begin
                ready = 1'b1;
                value = entry_value[idx];
            end else if (cdb1.tag == query_tag) begin
                ready = 1'b1;
                value = cdb1.value;
            end else if (cdb2.tag == query_tag) begin
                ready = 1'b1;
                value = cdb2.value;
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order CDB completion,
// in-order single retirement per cycle, two bypassing operand query ports.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alloc_valid,
    input  logic [REG_WIDTH-1:0]  alloc_rd,
    input  logic                  alloc_regwr,
    input  logic [PC_WIDTH-1:0]   alloc_pc,
    output logic                  alloc_ready,
    output logic [TAG_WIDTH-1:0]  alloc_tag,
    input  logic [TAG_WIDTH-1:0]  cdb1_tag,
    input  logic [DATA_WIDTH-1:0] cdb1_value,
    input  logic [TAG_WIDTH-1:0]  cdb2_tag,
    input  logic [DATA_WIDTH-1:0] cdb2_value,
    input  logic [TAG_WIDTH-1:0]  query1_tag,
    output logic                  query1_ready,
    output logic [DATA_WIDTH-1:0] query1_value,
    input  logic [TAG_WIDTH-1:0]  query2_tag,
    output logic                  query2_ready,
    output logic [DATA_WIDTH-1:0] query2_value,
    output logic                  retire_valid,
    output logic [TAG_WIDTH-1:0]  retire_tag,
    output logic [REG_WIDTH-1:0]  retire_rd,
    output logic                  retire_regwr,
    output logic [DATA_WIDTH-1:0] retire_value,
    output logic [PC_WIDTH-1:0]   retire_pc,
    input  logic                  flush,
    output logic                  full,
    output logic                  empty,
    output logic [TAG_WIDTH-1:0]  count
);

    rob_entry_t entry_q [ROB_SIZE];
    rob_entry_t entry_d [ROB_SIZE];
    idx_t       head_q, head_d;
    idx_t       tail_q, tail_d;
    tag_t       count_q, count_d;

    logic  retire_valid_q, retire_valid_d;
    tag_t  retire_tag_q, retire_tag_d;
    reg_t  retire_rd_q, retire_rd_d;
    logic  retire_regwr_q, retire_regwr_d;
    data_t retire_value_q, retire_value_d;
    pc_t   retire_pc_q, retire_pc_d;

    cdb_t cdb1, cdb2;
    idx_t cdb1_idx, cdb2_idx;
    logic cdb1_hit, cdb2_hit;
    logic alloc_fire, retire_fire;

    assign cdb1 = '{tag: cdb1_tag, value: cdb1_value};
    assign cdb2 = '{tag: cdb2_tag, value: cdb2_value};

    assign full        = (count_q == tag_t'(ROB_SIZE));
    assign empty       = (count_q == '0);
    assign count       = count_q;
    assign alloc_ready = !full;
    assign alloc_tag   = idx_to_tag(tail_q);

    assign alloc_fire  = alloc_valid && alloc_ready;
    // Retire decision uses stored state only, so a CDB result retires one cycle later at best.
    assign retire_fire = !empty && entry_q[head_q].valid && entry_q[head_q].ready;

    assign cdb1_idx = tag_to_idx(cdb1.tag);
    assign cdb2_idx = tag_to_idx(cdb2.tag);
    assign cdb1_hit = tag_in_range(cdb1.tag) && entry_q[cdb1_idx].valid &&
                      !(alloc_fire && (cdb1_idx == tail_q));
    assign cdb2_hit = tag_in_range(cdb2.tag) && entry_q[cdb2_idx].valid &&
                      !(alloc_fire && (cdb2_idx == tail_q));

    always_comb begin
        entry_d        = entry_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        retire_valid_d = 1'b0;
        retire_tag_d   = '0;
        retire_rd_d    = '0;
        retire_regwr_d = 1'b0;
        retire_value_d = '0;
        retire_pc_d    = '0;

        if (flush) begin
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                entry_d[i] = '0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // cdb2 first so that cdb1 overwrites on a tag collision
            if (cdb2_hit) begin
                entry_d[cdb2_idx].ready = 1'b1;
                entry_d[cdb2_idx].value = cdb2.value;
            end
            if (cdb1_hit) begin
                entry_d[cdb1_idx].ready = 1'b1;
                entry_d[cdb1_idx].value = cdb1.value;
            end

            if (alloc_fire) begin
                entry_d[tail_q] = '{valid: 1'b1, ready: 1'b0, regwr: alloc_regwr,
                                   rd: alloc_rd, value: '0, pc: alloc_pc};
                tail_d = next_idx(tail_q);
            end

            if (retire_fire) begin
                retire_valid_d  = 1'b1;
                retire_tag_d    = idx_to_tag(head_q);
                retire_rd_d     = entry_q[head_q].rd;
                retire_regwr_d  = entry_q[head_q].regwr;
                retire_value_d  = entry_q[head_q].value;
                retire_pc_d     = entry_q[head_q].pc;
                entry_d[head_q] = '0;
                head_d          = next_idx(head_q);
            end

            count_d = count_q + tag_t'(alloc_fire) - tag_t'(retire_fire);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                entry_q[i] <= '0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            retire_valid_q <= 1'b0;
            retire_tag_q   <= '0;
            retire_rd_q    <= '0;
            retire_regwr_q <= 1'b0;
            retire_value_q <= '0;
            retire_pc_q    <= '0;
        end else begin
            entry_q        <= entry_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            retire_valid_q <= retire_valid_d;
            retire_tag_q   <= retire_tag_d;
            retire_rd_q    <= retire_rd_d;
            retire_regwr_q <= retire_regwr_d;
            retire_value_q <= retire_value_d;
            retire_pc_q    <= retire_pc_d;
        end
    end

    assign retire_valid = retire_valid_q;
    assign retire_tag   = retire_tag_q;
    assign retire_rd    = retire_rd_q;
    assign retire_regwr = retire_regwr_q;
    assign retire_value = retire_value_q;
    assign retire_pc    = retire_pc_q;

    logic [ROB_SIZE-1:0] entry_valid, entry_ready;
    data_t               entry_value [ROB_SIZE];

    always_comb begin
        for (int unsigned i = 0; i < ROB_SIZE; i++) begin
            entry_valid[i] = entry_q[i].valid;
            entry_ready[i] = entry_q[i].ready;
            entry_value[i] = entry_q[i].value;
        end
    end

    rob_query_port u_query1 (
        .query_tag   (query1_tag),
        .entry_valid (entry_valid),
        .entry_ready (entry_ready),
        .entry_value (entry_value),
        .cdb1        (cdb1),
        .cdb2        (cdb2),
        .ready       (query1_ready),
        .value       (query1_value)
    );

    rob_query_port u_query2 (
        .query_tag   (query2_tag),
        .entry_valid (entry_valid),
        .entry_ready (entry_ready),
        .entry_value (entry_value),
        .cdb1        (cdb1),
        .cdb2        (cdb2),
        .ready       (query2_ready),
        .value       (query2_value)
    );

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomised scoreboard bench for reorder_buffer against a queue-based program-order model.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  alloc_valid;
    logic [REG_WIDTH-1:0]  alloc_rd;
    logic                  alloc_regwr;
    logic [PC_WIDTH-1:0]   alloc_pc;
    logic                  alloc_ready;
    logic [TAG_WIDTH-1:0]  alloc_tag;
    logic [TAG_WIDTH-1:0]  cdb1_tag, cdb2_tag;
    logic [DATA_WIDTH-1:0] cdb1_value, cdb2_value;
    logic [TAG_WIDTH-1:0]  query1_tag, query2_tag;
    logic                  query1_ready, query2_ready;
    logic [DATA_WIDTH-1:0] query1_value, query2_value;
    logic                  retire_valid;
    logic [TAG_WIDTH-1:0]  retire_tag;
    logic [REG_WIDTH-1:0]  retire_rd;
    logic                  retire_regwr;
    logic [DATA_WIDTH-1:0] retire_value;
    logic [PC_WIDTH-1:0]   retire_pc;
    logic                  flush;
    logic                  full, empty;
    logic [TAG_WIDTH-1:0]  count;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .alloc_valid  (alloc_valid),
        .alloc_rd     (alloc_rd),
        .alloc_regwr  (alloc_regwr),
        .alloc_pc     (alloc_pc),
        .alloc_ready  (alloc_ready),
        .alloc_tag    (alloc_tag),
        .cdb1_tag     (cdb1_tag),
        .cdb1_value   (cdb1_value),
        .cdb2_tag     (cdb2_tag),
        .cdb2_value   (cdb2_value),
        .query1_tag   (query1_tag),
        .query1_ready (query1_ready),
        .query1_value (query1_value),
        .query2_tag   (query2_tag),
        .query2_ready (query2_ready),
        .query2_value (query2_value),
        .retire_valid (retire_valid),
        .retire_tag   (retire_tag),
        .retire_rd    (retire_rd),
        .retire_regwr (retire_regwr),
        .retire_value (retire_value),
        .retire_pc    (retire_pc),
        .flush        (flush),
        .full         (full),
        .empty        (empty),
        .count        (count)
    );

    int tests = 0;
    int fails = 0;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: per-tag state plus a program-order list of live tags.
    logic        m_valid [1:ROB_SIZE];
    logic        m_ready [1:ROB_SIZE];
    logic [63:0] m_value [1:ROB_SIZE];
    logic [4:0]  m_rd    [1:ROB_SIZE];
    logic        m_regwr [1:ROB_SIZE];
    logic [63:0] m_pc    [1:ROB_SIZE];
    int          order[$];
    int          next_tag;

    typedef struct {
        logic        v;
        logic [4:0]  tag;
        logic [4:0]  rd;
        logic        regwr;
        logic [63:0] value;
        logic [63:0] pc;
    } ret_t;
    ret_t exp_q[$];
    ret_t mon_e;

    function automatic void model_clear();
        for (int t = 1; t <= 16; t++) begin
            m_valid[t] = 1'b0;
            m_ready[t] = 1'b0;
            m_value[t] = '0;
            m_rd[t]    = '0;
            m_regwr[t] = 1'b0;
            m_pc[t]    = '0;
        end
        order.delete();
        next_tag = 1;
    endfunction

    function automatic void model_query(input logic [4:0] tag, output logic rdy,
                                        output logic [63:0] val);
        int t = int'(tag);
        rdy = 1'b0;
        val = '0;
        if (t >= 1 && t <= 16 && m_valid[t]) begin
            if (m_ready[t]) begin
                rdy = 1'b1;
                val = m_value[t];
            end else if (cdb1_tag == tag) begin
                rdy = 1'b1;
                val = cdb1_value;
            end else if (cdb2_tag == tag) begin
                rdy = 1'b1;
                val = cdb2_value;
            end
        end
    endfunction

    function automatic void model_complete(input logic [4:0] tag, input logic [63:0] val);
        int t = int'(tag);
        if (t >= 1 && t <= 16 && m_valid[t]) begin
            m_ready[t] = 1'b1;
            m_value[t] = val;
        end
    endfunction

    function automatic void check_comb();
        logic        r;
        logic [63:0] v;
        chk("count", 64'(count), 64'(order.size()));
        chk("full", 64'(full), 64'(order.size() == 16));
        chk("empty", 64'(empty), 64'(order.size() == 0));
        chk("alloc_ready", 64'(alloc_ready), 64'(order.size() < 16));
        chk("alloc_tag", 64'(alloc_tag), 64'(next_tag));
        model_query(query1_tag, r, v);
        chk("query1_ready", 64'(query1_ready), 64'(r));
        chk("query1_value", query1_value, v);
        model_query(query2_tag, r, v);
        chk("query2_ready", 64'(query2_ready), 64'(r));
        chk("query2_value", query2_value, v);
    endfunction

    function automatic void model_step();
        ret_t r;
        bit   af, rf;
        int   h;
        r.v = 1'b0; r.tag = '0; r.rd = '0; r.regwr = 1'b0; r.value = '0; r.pc = '0;
        if (flush) begin
            model_clear();
        end else begin
            af = alloc_valid && (order.size() < 16);
            rf = (order.size() > 0) && m_ready[order[0]];
            if (rf) begin
                h       = order[0];
                r.v     = 1'b1;
                r.tag   = 5'(h);
                r.rd    = m_rd[h];
                r.regwr = m_regwr[h];
                r.value = m_value[h];
                r.pc    = m_pc[h];
            end
            model_complete(cdb2_tag, cdb2_value);
            model_complete(cdb1_tag, cdb1_value);
            if (af) begin
                m_valid[next_tag] = 1'b1;
                m_ready[next_tag] = 1'b0;
                m_value[next_tag] = '0;
                m_rd[next_tag]    = alloc_rd;
                m_regwr[next_tag] = alloc_regwr;
                m_pc[next_tag]    = alloc_pc;
                order.push_back(next_tag);
                next_tag = (next_tag % 16) + 1;
            end
            if (rf) begin
                m_valid[h] = 1'b0;
                m_ready[h] = 1'b0;
                void'(order.pop_front());
            end
        end
        exp_q.push_back(r);
    endfunction

    // Monitor: every edge produces exactly one expected retire record (possibly idle).
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("retire_valid", 64'(retire_valid), 64'(mon_e.v));
            chk("retire_tag", 64'(retire_tag), 64'(mon_e.tag));
            chk("retire_rd", 64'(retire_rd), 64'(mon_e.rd));
            chk("retire_regwr", 64'(retire_regwr), 64'(mon_e.regwr));
            chk("retire_value", retire_value, mon_e.value);
            chk("retire_pc", retire_pc, mon_e.pc);
        end
    end

    task automatic idle_inputs();
        alloc_valid = 1'b0; alloc_rd = '0; alloc_regwr = 1'b0; alloc_pc = '0;
        cdb1_tag = '0; cdb1_value = '0; cdb2_tag = '0; cdb2_value = '0;
        query1_tag = '0; query2_tag = '0; flush = 1'b0;
    endtask

    // Called just after a negedge with inputs already driven.
    task automatic cycle();
        #1;
        check_comb();
        model_step();
        @(negedge clk);
    endtask

    task automatic do_alloc(input logic [4:0] rd, input logic regwr);
        idle_inputs();
        alloc_valid = 1'b1;
        alloc_rd    = rd;
        alloc_regwr = regwr;
        alloc_pc    = {$urandom, $urandom};
        cycle();
    endtask

    task automatic do_cdb1(input int tag, input logic [63:0] val);
        idle_inputs();
        cdb1_tag   = 5'(tag);
        cdb1_value = val;
        cycle();
    endtask

    task automatic async_reset();
        idle_inputs();
        #3;
        reset = 1'b0;
        #1;
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_alloc_tag", 64'(alloc_tag), 64'd1);
        chk("rst_retire_valid", 64'(retire_valid), 64'd0);
        model_clear();
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [4:0] pick_tag();
        int r = int'($urandom_range(0, 9));
        if (r <= 5 && order.size() > 0) return 5'(order[$urandom_range(0, order.size() - 1)]);
        if (r <= 7) return 5'd0;
        if (r == 8) return 5'($urandom_range(1, 16));
        return 5'($urandom_range(17, 31));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        model_clear();
        repeat (2) @(negedge clk);
        chk("init_empty", 64'(empty), 64'd1);
        chk("init_alloc_tag", 64'(alloc_tag), 64'd1);
        chk("init_retire_valid", 64'(retire_valid), 64'd0);
        reset = 1'b1;

        // Asynchronous reset with live entries
        for (int i = 0; i < 3; i++) do_alloc(5'(i + 1), 1'b1);
        async_reset();

        // In-order retirement despite out-of-order completion
        do_alloc(5'd5, 1'b1);
        do_alloc(5'd6, 1'b1);
        do_alloc(5'd7, 1'b1);
        do_cdb1(2, 64'hAA);
        do_cdb1(1, 64'h11);
        idle_inputs();
        repeat (4) cycle();
        chk("inorder_count", 64'(count), 64'd1);

        // Fill, blocked alloc during retire, wrap of the allocation tag
        idle_inputs(); flush = 1'b1; cycle();
        for (int i = 0; i < 16; i++) do_alloc(5'($urandom_range(0, 31)), 1'b1);
        chk("full_flag", 64'(full), 64'd1);
        chk("full_alloc_ready", 64'(alloc_ready), 64'd0);
        do_cdb1(1, 64'h1234);
        do_alloc(5'd9, 1'b1);
        chk("full_ignored_count", 64'(count), 64'd15);
        chk("wrap_alloc_tag", 64'(alloc_tag), 64'd1);
        do_alloc(5'd10, 1'b0);
        chk("wrap_count", 64'(count), 64'd16);

        // CDB collision: cdb1 wins
        idle_inputs();
        cdb1_tag = 5'd4; cdb1_value = 64'd1;
        cdb2_tag = 5'd4; cdb2_value = 64'd2;
        cycle();
        idle_inputs();
        query1_tag = 5'd4;
        #1;
        chk("collide_ready", 64'(query1_ready), 64'd1);
        chk("collide_value", query1_value, 64'd1);
        cycle();

        // Same-cycle bypass and tag-0 query
        idle_inputs();
        query1_tag = 5'd3; query2_tag = 5'd0;
        cdb2_tag = 5'd3; cdb2_value = 64'h55;
        #1;
        chk("bypass_ready", 64'(query1_ready), 64'd1);
        chk("bypass_value", query1_value, 64'h55);
        chk("tag0_ready", 64'(query2_ready), 64'd0);
        cycle();

        // Flush beats a ready head and a concurrent alloc
        idle_inputs(); flush = 1'b1; cycle();
        for (int i = 0; i < 5; i++) do_alloc(5'(i), 1'b1);
        do_cdb1(1, 64'hBEEF);
        idle_inputs();
        flush = 1'b1; alloc_valid = 1'b1; alloc_rd = 5'd3;
        cycle();
        chk("flush_retire_valid", 64'(retire_valid), 64'd0);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_alloc_tag", 64'(alloc_tag), 64'd1);
        chk("flush_empty", 64'(empty), 64'd1);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) async_reset();
            idle_inputs();
            alloc_valid = ($urandom_range(0, 9) < 6);
            alloc_rd    = 5'($urandom);
            alloc_regwr = 1'($urandom);
            alloc_pc    = {$urandom, $urandom};
            cdb1_tag    = pick_tag();
            cdb1_value  = {$urandom, $urandom};
            cdb2_tag    = pick_tag();
            cdb2_value  = {$urandom, $urandom};
            query1_tag  = pick_tag();
            query2_tag  = pick_tag();
            flush       = ($urandom_range(0, 63) == 0);
            cycle();
        end

        idle_inputs();
        repeat (4) cycle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
